// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: decodes the immediate field of a 32-bit instruction
// word according to immSrc, sign/zero-extends it to XLEN and queues the
// result with its sideband tag in a 2-entry FIFO using a valid/ready handshake.
//
// Optional build macro: IMM_CSR_ZIMM_EN
//   defined   -> immSrc=110 decodes the CSR zimm field, zext(instr[19:15])
//   undefined -> immSrc=110 is unsupported (result 0, bad=1)
module imm_extend_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       immSrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  immExt,
    output logic [TAG_W-1:0] out_tag,
    output logic             bad
);

    logic [31:0]      raw;
    logic             sext;
    logic             bad_d;
    logic [XLEN-1:0]  imm_d;

    logic [XLEN-1:0]  imm_q [2];
    logic [TAG_W-1:0] tag_q [2];
    logic             bad_q [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;

    logic             push;
    logic             pop;
    logic             unused_opcode;

    // opcode bits never contribute to any immediate format
    assign unused_opcode = ^instr[6:0];

    // Decode the immediate to a 32-bit value, then widen it to XLEN.
    always_comb begin
        raw   = '0;
        sext  = 1'b0;
        bad_d = 1'b0;
        case (immSrc)
            3'b000: begin
                raw  = {{20{instr[31]}}, instr[31:20]};
                sext = 1'b1;
            end
            3'b001: begin
                raw  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                sext = 1'b1;
            end
            3'b010: begin
                raw  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                        instr[11:8], 1'b0};
                sext = 1'b1;
            end
            3'b011: begin
                raw  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                        instr[30:21], 1'b0};
                sext = 1'b1;
            end
            3'b100: begin
                raw  = {instr[31:12], 12'b0};
                sext = 1'b1;
            end
            3'b101: begin
                // RV64 shift amounts carry one extra bit
                raw = {26'b0, (XLEN == 64) ? instr[25] : 1'b0, instr[24:20]};
            end
`ifdef IMM_CSR_ZIMM_EN
            3'b110: begin
                raw = {27'b0, instr[19:15]};
            end
`else
            3'b110: begin
                bad_d = 1'b1;
            end
`endif
            default: begin
                bad_d = 1'b1;
            end
        endcase

        if (sext) begin
            imm_d = XLEN'($signed(raw));
        end else begin
            imm_d = XLEN'(raw);
        end
    end

    // in_ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    // Occupancy and pointers; flush empties the buffer and drops any push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage written at the tail on each accepted request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                imm_q[i] <= '0;
                tag_q[i] <= '0;
                bad_q[i] <= 1'b0;
            end
        end else if (push) begin
            imm_q[wr_ptr] <= imm_d;
            tag_q[wr_ptr] <= in_tag;
            bad_q[wr_ptr] <= bad_d;
        end
    end

    // Head entry is visible only while valid; otherwise outputs read as zero.
    always_comb begin
        immExt  = '0;
        out_tag = '0;
        bad     = 1'b0;
        if (out_valid) begin
            immExt  = imm_q[rd_ptr];
            out_tag = tag_q[rd_ptr];
            bad     = bad_q[rd_ptr];
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe; an XLEN=32 and an XLEN=64 instance
// share the same stimulus and are checked against hand-computed values.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] instr;
    logic [2:0]  immSrc;
    logic [4:0]  in_tag;
    logic        out_ready;

    logic        in_ready, out_valid, bad;
    logic [31:0] immExt;
    logic [4:0]  out_tag;

    logic        in_ready64, out_valid64, bad64;
    logic [63:0] immExt64;
    logic [4:0]  out_tag64;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    imm_extend_pipe #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .immSrc(immSrc), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .immExt(immExt), .out_tag(out_tag), .bad(bad)
    );

    imm_extend_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .immSrc(immSrc), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .immExt(immExt64), .out_tag(out_tag64), .bad(bad64)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push one request with out_ready high, check it one cycle later, then let it pop.
    task automatic decode(input string name, input logic [31:0] ins, input logic [2:0] src,
                          input logic [4:0] tag, input logic [63:0] e32, input logic [63:0] e64,
                          input logic ebad);
        instr    = ins;
        immSrc   = src;
        in_tag   = tag;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk({name, " valid"},   {63'b0, out_valid}, 64'd1);
        chk({name, " imm32"},   {32'b0, immExt}, e32);
        chk({name, " imm64"},   immExt64, e64);
        chk({name, " tag"},     {59'b0, out_tag}, {59'b0, tag});
        chk({name, " bad"},     {63'b0, bad}, {63'b0, ebad});
        chk({name, " bad64"},   {63'b0, bad64}, {63'b0, ebad});
        step();
        chk({name, " drained"}, {63'b0, out_valid}, 64'd0);
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        instr     = '0;
        immSrc    = '0;
        in_tag    = '0;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst immExt",    {32'b0, immExt}, 64'd0);
        chk("rst out_tag",   {59'b0, out_tag}, 64'd0);
        chk("rst bad",       {63'b0, bad}, 64'd0);
        reset = 1'b0;
        step();
        chk("post rst in_ready", {63'b0, in_ready}, 64'd1);

        decode("I",    32'hFFF00093, 3'b000, 5'd1, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        decode("S",    32'hFE112E23, 3'b001, 5'd2, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        decode("B",    32'hFE000EE3, 3'b010, 5'd3, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        decode("J",    32'hFFDFF06F, 3'b011, 5'd4, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        decode("U",    32'h123450B7, 3'b100, 5'd5, 64'h12345000, 64'h0000000012345000, 1'b0);
        decode("Uneg", 32'h80000037, 3'b100, 5'd6, 64'h80000000, 64'hFFFFFFFF80000000, 1'b0);
        decode("SH",   32'h4050D093, 3'b101, 5'd7, 64'h5, 64'h5, 1'b0);
        decode("SH6",  32'h03F0D093, 3'b101, 5'd8, 64'h1F, 64'h3F, 1'b0);
`ifdef IMM_CSR_ZIMM_EN
        decode("Z",    32'h300FD073, 3'b110, 5'd9, 64'h1F, 64'h1F, 1'b0);
`else
        decode("Z",    32'h300FD073, 3'b110, 5'd9, 64'h0, 64'h0, 1'b1);
`endif
        decode("bad7", 32'hFFFFFFFF, 3'b111, 5'd10, 64'h0, 64'h0, 1'b1);

        // backpressure: three requests against a 2-deep buffer
        out_ready = 1'b0;
        instr     = 32'h123450B7;
        immSrc    = 3'b100;
        in_tag    = 5'd1;
        in_valid  = 1'b1;
        chk("bp ready0", {63'b0, in_ready}, 64'd1);
        step();
        in_tag = 5'd2;
        chk("bp ready1", {63'b0, in_ready}, 64'd1);
        step();
        in_tag = 5'd3;
        chk("bp full", {63'b0, in_ready}, 64'd0);
        step();
        chk("bp held ready", {63'b0, in_ready}, 64'd0);
        chk("bp head tag",   {59'b0, out_tag}, 64'd1);
        chk("bp head imm",   {32'b0, immExt}, 64'h12345000);
        out_ready = 1'b1;
        step();
        chk("bp pop1 tag",   {59'b0, out_tag}, 64'd2);
        chk("bp pop1 ready", {63'b0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
        chk("bp pushpop tag",   {59'b0, out_tag}, 64'd3);
        chk("bp pushpop valid", {63'b0, out_valid}, 64'd1);
        chk("bp pushpop ready", {63'b0, in_ready}, 64'd1);
        step();
        chk("bp drained", {63'b0, out_valid}, 64'd0);

        // flush with two entries buffered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tag    = 5'd4;
        step();
        in_tag = 5'd5;
        step();
        chk("fl full", {63'b0, in_ready}, 64'd0);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl valid", {63'b0, out_valid}, 64'd0);
        chk("fl ready", {63'b0, in_ready}, 64'd1);
        chk("fl tag",   {59'b0, out_tag}, 64'd0);

        // flush discards a same-cycle push
        in_valid = 1'b1;
        in_tag   = 5'd6;
        step();
        flush  = 1'b1;
        in_tag = 5'd7;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl push valid", {63'b0, out_valid}, 64'd0);
        step();
        chk("fl push stays empty", {63'b0, out_valid}, 64'd0);

        // asynchronous reset mid-stream
        in_valid = 1'b1;
        in_tag   = 5'd9;
        immSrc   = 3'b000;
        instr    = 32'hFFF00093;
        step();
        in_valid = 1'b0;
        chk("ar before valid", {63'b0, out_valid}, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar valid", {63'b0, out_valid}, 64'd0);
        chk("ar imm",   {32'b0, immExt}, 64'd0);
        chk("ar imm64", immExt64, 64'd0);
        chk("ar tag",   {59'b0, out_tag}, 64'd0);
        chk("ar bad",   {63'b0, bad}, 64'd0);
        step();
        reset = 1'b0;
        step();
        chk("ar ready", {63'b0, in_ready}, 64'd1);
        chk("ar stays empty", {63'b0, out_valid}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
